keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, debounces presses and releases, and decodes each accepted press to a 4-bit hex digit. Keeps the two most recent digits, `s0` (newest) and `s1` (previous). These feed the time-multiplexed dual seven-segment display stage directly downstream, which renders `s0` and `s1` and their sum. One `key_valid` pulse per accepted press.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_scanner_sync2.sv | 31 +++
 rtl/keypad_scanner.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   kp_state_t    - scanner FSM states
//   lo_idx_t      - result of onehot_lo_idx (valid flag + row index)
//   KEY_MAP       - hex digit for each [row][col] switch position
//   onehot_lo_idx - index of the single low bit of an active-low row pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } lo_idx_t;

  // Keypad legend, indexed [row][col].
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Zero or several low rows is not a single key, so valid stays 0.
  function automatic lo_idx_t onehot_lo_idx(input logic [3:0] v);
    lo_idx_t r;
    r = '{valid: 1'b0, idx: 2'd0};
    case (v)
      4'b1110: r = '{valid: 1'b1, idx: 2'd0};
      4'b1101: r = '{valid: 1'b1, idx: 2'd1};
      4'b1011: r = '{valid: 1'b1, idx: 2'd2};
      4'b0111: r = '{valid: 1'b1, idx: 2'd3};
      default: r = '{valid: 1'b0, idx: 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, loads RST_VAL into both flops
//   d     - asynchronous input bus
//   q     - synchronized output (2 cycles of latency)
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, decodes each accepted press to a hex digit and keeps the two most
// recent digits for the display stage downstream.
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   rows      - keypad rows, active-low, asynchronous to clk
//   cols      - column drive, active-low, exactly one bit low
//   key       - digit of the last accepted press
//   key_valid - one-cycle pulse when key/s0/s1 update
//   s0, s1    - newest and previous digit
// Build option: define KEYPAD_REPEAT_EN to re-emit a held key every
// REPEAT_CYCLES cycles.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic [3:0] s0,
  output logic [3:0] s1
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] rs;

  sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_rows_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (rows),
    .q     (rs)
  );

  kp_state_t     state_q,     state_d;
  logic [1:0]    col_idx_q,   col_idx_d;
  logic [SW-1:0] scan_cnt_q,  scan_cnt_d;
  logic [DW-1:0] db_cnt_q,    db_cnt_d;
  logic [3:0]    row_pat_q,   row_pat_d;
  logic [1:0]    row_idx_q,   row_idx_d;
  logic [3:0]    key_q,       key_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    s0_q,        s0_d;
  logic [3:0]    s1_q,        s1_d;
  logic          emit;
  lo_idx_t       hit;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  always_comb begin
    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    row_pat_d   = row_pat_q;
    row_idx_d   = row_idx_q;
    key_d       = key_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    key_valid_d = 1'b0;
    emit        = 1'b0;
    hit         = onehot_lo_idx(rs);
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif

    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (hit.valid) begin
            // Column stays parked on the pressed key while it is debounced.
            row_pat_d = rs;
            row_idx_d = hit.idx;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rs != row_pat_q) begin
          db_cnt_d  = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (db_cnt_q == DB_LAST) begin
          db_cnt_d = '0;
          emit     = 1'b1;
          state_d  = HELD;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      HELD: begin
        // Any other key pressed now just keeps us here until all rows are high.
        if (rs == 4'hF) begin
          db_cnt_d = '0;
          state_d  = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          emit      = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
      end

      RELEASE: begin
        if (rs != 4'hF) begin
          db_cnt_d = '0;
          state_d  = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          db_cnt_d  = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase

    if (emit) begin
      key_d       = KEY_MAP[row_idx_q][col_idx_q];
      s1_d        = s0_q;
      s0_d        = key_d;
      key_valid_d = 1'b1;
    end

`ifdef KEYPAD_REPEAT_EN
    // Held at zero outside HELD, so entering HELD always starts a fresh interval.
    if (state_d != HELD) rep_cnt_d = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      row_pat_q   <= 4'hF;
      row_idx_q   <= 2'd0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      s0_q        <= 4'h0;
      s1_q        <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      row_pat_q   <= row_pat_d;
      row_idx_q   <= row_idx_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign cols      = ~(4'b0001 << col_idx_q);
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign s0        = s0_q;
  assign s1        = s1_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a switch-matrix
// keypad model, a digit-history reference model checked every cycle, directed
// cases with hand-computed timing and a randomized press sequence.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 8;
  localparam int REP      = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic [3:0]  s0;
  logic [3:0]  s1;
  logic [15:0] pressed = '0;   // switch (r,c) at bit r*4+c

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .s0        (s0),
    .s1        (s1)
  );

  // Switch matrix: a row reads low when a closed switch ties it to a driven column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Keypad legend as printed on the keys, row-major.
  logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model: digit history plus which key (if any) may legally produce pulses.
  logic [3:0] m_key = '0;
  logic [3:0] m_s0  = '0;
  logic [3:0] m_s1  = '0;
  logic       prev_kv = 1'b0;
  int         active = -1;
  int         win_pulses = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_key = '0; m_s0 = '0; m_s1 = '0; prev_kv = 1'b0;
      check("rst_cols", cols, 4'b1110);
      check("rst_key_valid", key_valid, 0);
      check("rst_key", key, 0);
      check("rst_s0", s0, 0);
      check("rst_s1", s1, 0);
    end else begin
      check("cols_one_low", $countones(~cols), 1);
      if (key_valid) begin
        win_pulses++;
        check("key_valid_width", prev_kv, 0);
        if (active < 0) check("spurious_key_valid", key_valid, 0);
        else begin
          m_s1  = m_s0;
          m_s0  = legend[active];
          m_key = m_s0;
        end
      end
      prev_kv = key_valid;
      check("key", key, m_key);
      check("s0", s0, m_s0);
      check("s1", s1, m_s1);
    end
  end

  // Reset, then release it with the given switches already closed; the next
  // rising edge is edge 1 of the new run.
  task automatic do_reset(input logic [15:0] keys);
    @(posedge clk); #2;
    reset_n = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    #2;
    pressed = keys;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Press one switch for len cycles; designate marks it as a press that may
  // produce pulses (the window closes a few cycles after release).
  task automatic press(input int idx, input int len, input bit designate);
    win_pulses = 0;
    active = designate ? idx : -1;
    pressed[idx] = 1'b1;
    idle(len);
    pressed[idx] = 1'b0;
    idle(6);
    active = -1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] exp_cols;
    int k;
    int r1, r2, c, len, evt;

    // Reset values and column rotation, then a two-row press in column 2.
    do_reset('0);
    #1;
    check("post_reset_cols", cols, 4'b1110);
    check("post_reset_key_valid", key_valid, 0);
    win_pulses = 0;
    for (int e = 1; e <= 66; e++) begin
      @(posedge clk); #1;
      exp_cols = ~(4'b0001 << ((e / 4) % 4));
      check("rotate_cols", cols, exp_cols);
      if (e == 16) begin pressed[2] = 1'b1; pressed[6] = 1'b1; end
      if (e == 66) pressed = '0;
    end
    idle(10);
    check("dual_press_pulses", win_pulses, 0);

    // Key '6' held 100 cycles.
    do_reset('0);
    press(6, 100, 1'b1);
    idle(20);
`ifdef KEYPAD_REPEAT_EN
    check("key6_pulses", win_pulses, 3);
    check("key6_s1", s1, 6);
`else
    check("key6_pulses", win_pulses, 1);
    check("key6_s1", s1, 0);
`endif
    check("key6_key", key, 6);
    check("key6_s0", s0, 6);

    // '5' then '9'.
    press(5, 35, 1'b1);
    idle(30);
    check("key5_pulses", win_pulses, 1);
    press(10, 35, 1'b1);
    idle(30);
    check("key9_pulses", win_pulses, 1);
    check("seq_s0", s0, 9);
    check("seq_s1", s1, 5);

    // Brief press of '1' that drops out during debounce.
    win_pulses = 0;
    do_reset(16'h0001);
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      if (e == 6) begin #1; pressed = '0; end
      if (e == 9)  check("abort_cols_e9", cols, 4'b1101);
      if (e == 13) check("abort_cols_e13", cols, 4'b1011);
    end
    idle(50);
    check("abort_pulses", win_pulses, 0);

    // Accept latency for '1' pressed at reset release: DEBOUNCE entered at edge 4.
    win_pulses = 0;
    active = 0;
    do_reset(16'h0001);
    k = 41;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (key_valid) begin k = e; break; end
    end
    check("accept_latency_edge", k, 4 + DB);
    check("latency_key", key, 1);
    idle(20);
    pressed = '0;
    idle(6);
    active = -1;
    idle(20);
    check("latency_pulses", win_pulses, 1);

    // Reset in the middle of debouncing 'A' (DEBOUNCE spans edges 16..23).
    win_pulses = 0;
    do_reset(16'h0008);
    repeat (19) @(posedge clk);
    #1;
    check("pre_reset_cols", cols, 4'b0111);
    reset_n = 1'b0;
    #1;
    check("async_reset_cols", cols, 4'b1110);
    check("async_reset_key_valid", key_valid, 0);
    pressed = '0;
    idle(2);
    reset_n = 1'b1;
    idle(60);
    check("reset_abort_pulses", win_pulses, 0);

    // Key '3' held 100 cycles past acceptance (accepted at edge 20).
    win_pulses = 0;
    active = 2;
    do_reset(16'h0004);
    idle(120);
    pressed = '0;
    idle(10);
    active = -1;
    idle(20);
`ifdef KEYPAD_REPEAT_EN
    check("hold3_pulses", win_pulses, 4);
    check("hold3_s1", s1, 3);
`else
    check("hold3_pulses", win_pulses, 1);
    check("hold3_s1", s1, 0);
`endif
    check("hold3_s0", s0, 3);

    // Randomized sequence: glitches, two-key presses in one column, real presses.
    for (int n = 0; n < 16; n++) begin
      evt = $urandom_range(0, 9);
      if (evt < 2) begin
        press($urandom_range(0, 15), $urandom_range(1, 6), 1'b0);
        check("rand_glitch_pulses", win_pulses, 0);
      end else if (evt < 4) begin
        c  = $urandom_range(0, 3);
        r1 = $urandom_range(0, 3);
        r2 = (r1 + 1 + $urandom_range(0, 2)) % 4;
        win_pulses = 0;
        pressed[r1*4+c] = 1'b1;
        pressed[r2*4+c] = 1'b1;
        idle($urandom_range(20, 50));
        pressed = '0;
        idle(6);
        check("rand_dual_pulses", win_pulses, 0);
      end else begin
        len = $urandom_range(35, 60);
        press($urandom_range(0, 15), len, 1'b1);
`ifdef KEYPAD_REPEAT_EN
        check("rand_press_pulses_in_range", int'(win_pulses >= 1 && win_pulses <= 2), 1);
`else
        check("rand_press_pulses", win_pulses, 1);
`endif
      end
      idle($urandom_range(25, 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
